// File: rtl/schedule_arbiter_pkg.sv
// rtl/schedule_arbiter_pkg.sv - shared constants and types for the page-command schedule arbiter
package schedule_arbiter_pkg;

    localparam int NUM_REQ_DEF = 3;

    localparam int REQ_RD    = 0;
    localparam int REQ_PROG  = 1;
    localparam int REQ_ERASE = 2;

    localparam int CMD_W   = 16;
    localparam int ID_W    = 16;
    localparam int ADDR_W  = 48;
    localparam int PARAM_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/schedule_arbiter_rr_pick.sv
// rtl/schedule_arbiter_rr_pick.sv - combinational round-robin pick starting after the last grant
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int GW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last,
    output logic [GW-1:0]      next,
    output logic               any
);

    logic          found_hi;
    logic          found_lo;
    logic [GW-1:0] pick_hi;
    logic [GW-1:0] pick_lo;

    // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j] && (j > int'(last))) begin
                found_hi = 1'b1;
                pick_hi  = GW'(j);
            end
            if (req[j]) begin
                found_lo = 1'b1;
                pick_lo  = GW'(j);
            end
        end
        any  = found_lo;
        next = found_hi ? pick_hi : (found_lo ? pick_lo : last);
    end

endmodule

// File: rtl/schedule_arbiter.sv
// rtl/schedule_arbiter.sv - round-robin arbiter merging page-command streams into one registered output
module schedule_arbiter
    import schedule_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int GW      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [CMD_W*NUM_REQ-1:0]   i_req_cmd,
    input  logic [NUM_REQ-1:0]         i_req_last,
    input  logic [ID_W*NUM_REQ-1:0]    i_req_id,
    input  logic [ADDR_W*NUM_REQ-1:0]  i_req_addr,
    input  logic [PARAM_W*NUM_REQ-1:0] i_req_param,
    input  logic                       i_page_cmd_ready,
    output logic                       o_page_cmd_valid,
    output logic [CMD_W-1:0]           o_page_cmd,
    output logic                       o_page_cmd_last,
    output logic [ID_W-1:0]            o_page_cmd_id,
    output logic [ADDR_W-1:0]          o_page_addr,
    output logic [PARAM_W-1:0]         o_page_cmd_param,
    output logic [GW-1:0]              o_grant,
    output logic                       o_busy
);

    arb_state_t         state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PARAM_W-1:0] param_q, param_d;

    logic [CMD_W-1:0]   cmd_arr   [NUM_REQ];
    logic [ID_W-1:0]    id_arr    [NUM_REQ];
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [PARAM_W-1:0] param_arr [NUM_REQ];

    logic          slot_free;
    logic          accept;
    logic [GW-1:0] rr_next;
    logic          rr_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .req  (i_req_valid),
        .last (grant_q),
        .next (rr_next),
        .any  (rr_any)
    );

    // Unpack the flat requester buses so the granted slice can be picked by index.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cmd_arr[k]   = i_req_cmd[k*CMD_W +: CMD_W];
            id_arr[k]    = i_req_id[k*ID_W +: ID_W];
            addr_arr[k]  = i_req_addr[k*ADDR_W +: ADDR_W];
            param_arr[k] = i_req_param[k*PARAM_W +: PARAM_W];
        end
    end

    // Only the owner sees ready, and only while the output register can take a beat.
    always_comb begin
        slot_free = ~valid_q | i_page_cmd_ready;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = ~rst & (state_q == ST_GRANT) & slot_free & (grant_q == GW'(k));
        end
        accept = (state_q == ST_GRANT) & slot_free & i_req_valid[grant_q];
    end

    // Next-state: arbitration in IDLE, beat transfer and sequence tracking in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        cmd_d   = cmd_q;
        last_d  = last_q;
        id_d    = id_q;
        addr_d  = addr_q;
        param_d = param_q;

        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_d = rr_next;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept && i_req_last[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            valid_d = 1'b1;
            cmd_d   = cmd_arr[grant_q];
            last_d  = i_req_last[grant_q];
            id_d    = id_arr[grant_q];
            addr_d  = addr_arr[grant_q];
            param_d = param_arr[grant_q];
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
    end

    // State, grant and output registers; reset parks the grant on the last requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= GW'(NUM_REQ - 1);
            valid_q <= 1'b0;
            cmd_q   <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            param_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            last_q  <= last_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            param_q <= param_d;
        end
    end

    assign o_page_cmd_valid = valid_q;
    assign o_page_cmd       = cmd_q;
    assign o_page_cmd_last  = last_q;
    assign o_page_cmd_id    = id_q;
    assign o_page_addr      = addr_q;
    assign o_page_cmd_param = param_q;
    assign o_grant          = grant_q;
    assign o_busy           = (state_q == ST_GRANT);

endmodule

// File: tb/tb_schedule_arbiter.sv
// tb/tb_schedule_arbiter.sv - directed self-checking bench for schedule_arbiter
module tb_schedule_arbiter;
    import schedule_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      i_req_valid;
    logic [N-1:0]      o_req_ready;
    logic [16*N-1:0]   i_req_cmd;
    logic [N-1:0]      i_req_last;
    logic [16*N-1:0]   i_req_id;
    logic [48*N-1:0]   i_req_addr;
    logic [32*N-1:0]   i_req_param;
    logic              i_page_cmd_ready;
    logic              o_page_cmd_valid;
    logic [15:0]       o_page_cmd;
    logic              o_page_cmd_last;
    logic [15:0]       o_page_cmd_id;
    logic [47:0]       o_page_addr;
    logic [31:0]       o_page_cmd_param;
    logic [GW-1:0]     o_grant;
    logic              o_busy;

    int tests = 0;
    int fails = 0;

    schedule_arbiter #(.NUM_REQ(N), .GW(GW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_cmd        (i_req_cmd),
        .i_req_last       (i_req_last),
        .i_req_id         (i_req_id),
        .i_req_addr       (i_req_addr),
        .i_req_param      (i_req_param),
        .i_page_cmd_ready (i_page_cmd_ready),
        .o_page_cmd_valid (o_page_cmd_valid),
        .o_page_cmd       (o_page_cmd),
        .o_page_cmd_last  (o_page_cmd_last),
        .o_page_cmd_id    (o_page_cmd_id),
        .o_page_addr      (o_page_addr),
        .o_page_cmd_param (o_page_cmd_param),
        .o_grant          (o_grant),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [15:0] cmd, input logic last,
                           input logic [15:0] id, input logic [47:0] addr, input logic [31:0] param);
        i_req_valid[k]           = v;
        i_req_cmd[k*16 +: 16]    = cmd;
        i_req_last[k]            = last;
        i_req_id[k*16 +: 16]     = id;
        i_req_addr[k*48 +: 48]   = addr;
        i_req_param[k*32 +: 32]  = param;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle();
        chk("ready_in_reset", 64'(o_req_ready), 64'd0);
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] rot [4];

    initial begin
        rst = 1'b1;
        i_req_valid = '0; i_req_cmd = '0; i_req_last = '0;
        i_req_id = '0; i_req_addr = '0; i_req_param = '0;
        i_page_cmd_ready = 1'b1;
        rot[0] = 2'd0; rot[1] = 2'd1; rot[2] = 2'd2; rot[3] = 2'd0;

        tick();
        do_reset();
        chk("rst_valid", 64'(o_page_cmd_valid), 64'd0);
        chk("rst_grant", 64'(o_grant), 64'd2);
        chk("rst_busy",  64'(o_busy), 64'd0);
        chk("rst_cmd",   64'(o_page_cmd), 64'd0);
        chk("rst_addr",  64'(o_page_addr), 64'd0);
        chk("rst_ready", 64'(o_req_ready), 64'd0);

        // single beat from the prog requester
        set_req(REQ_PROG, 1'b1, 16'h1080, 1'b1, 16'h0005, 48'h123456789ABC, 32'hDEADBEEF);
        tick();
        settle();
        chk("a_grant", 64'(o_grant), 64'd1);
        chk("a_busy",  64'(o_busy), 64'd1);
        chk("a_ready", 64'(o_req_ready), 64'b010);
        chk("a_valid_early", 64'(o_page_cmd_valid), 64'd0);
        tick();
        set_req(REQ_PROG, 1'b0, 16'h0, 1'b0, 16'h0, 48'h0, 32'h0);
        chk("a_valid", 64'(o_page_cmd_valid), 64'd1);
        chk("a_cmd",   64'(o_page_cmd), 64'h1080);
        chk("a_id",    64'(o_page_cmd_id), 64'h5);
        chk("a_last",  64'(o_page_cmd_last), 64'd1);
        chk("a_addr",  64'(o_page_addr), 64'h123456789ABC);
        chk("a_param", 64'(o_page_cmd_param), 64'hDEADBEEF);
        chk("a_idle",  64'(o_busy), 64'd0);
        tick();
        chk("a_drain", 64'(o_page_cmd_valid), 64'd0);
        chk("a_hold",  64'(o_page_cmd), 64'h1080);

        // strict rotation with all requesters valid
        do_reset();
        for (int k = 0; k < N; k++)
            set_req(k, 1'b1, 16'hA000 + 16'(k), 1'b1, 16'(k), 48'(k), 32'(k));
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("b_grant", 64'(o_grant), 64'(rot[n]));
            tick();
            chk("b_valid", 64'(o_page_cmd_valid), 64'd1);
            chk("b_cmd",   64'(o_page_cmd), 64'(16'hA000 + 16'(rot[n])));
        end
        i_req_valid = '0;

        // three-beat sequence from read requester while prog waits
        do_reset();
        set_req(REQ_RD, 1'b1, 16'hB000, 1'b0, 16'h10, 48'h0, 32'h0);
        set_req(REQ_PROG, 1'b1, 16'hC100, 1'b1, 16'h11, 48'h0, 32'h0);
        tick();
        settle();
        chk("c_grant0", 64'(o_grant), 64'd0);
        chk("c_ready0", 64'(o_req_ready), 64'b001);
        tick();
        set_req(REQ_RD, 1'b1, 16'hB001, 1'b0, 16'h10, 48'h0, 32'h0);
        chk("c_beat0", 64'(o_page_cmd), 64'hB000);
        chk("c_busy",  64'(o_busy), 64'd1);
        tick();
        set_req(REQ_RD, 1'b1, 16'hB002, 1'b1, 16'h10, 48'h0, 32'h0);
        chk("c_beat1", 64'(o_page_cmd), 64'hB001);
        chk("c_v1",    64'(o_page_cmd_valid), 64'd1);
        tick();
        i_req_valid[REQ_RD] = 1'b0;
        chk("c_beat2", 64'(o_page_cmd), 64'hB002);
        chk("c_last2", 64'(o_page_cmd_last), 64'd1);
        chk("c_idle",  64'(o_busy), 64'd0);
        tick();
        chk("c_grant1", 64'(o_grant), 64'd1);
        chk("c_gap",    64'(o_page_cmd_valid), 64'd0);
        tick();
        i_req_valid[REQ_PROG] = 1'b0;
        chk("c_p_cmd",   64'(o_page_cmd), 64'hC100);
        chk("c_p_valid", 64'(o_page_cmd_valid), 64'd1);

        // downstream stall with a valid output
        i_page_cmd_ready = 1'b0;
        set_req(REQ_ERASE, 1'b1, 16'hD200, 1'b1, 16'h22, 48'h0, 32'h0);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("d_ready", 64'(o_req_ready), 64'd0);
            chk("d_valid", 64'(o_page_cmd_valid), 64'd1);
            chk("d_cmd",   64'(o_page_cmd), 64'hC100);
        end
        chk("d_grant", 64'(o_grant), 64'd2);
        i_page_cmd_ready = 1'b1;
        settle();
        chk("d_ready_up", 64'(o_req_ready), 64'b100);
        tick();
        i_req_valid[REQ_ERASE] = 1'b0;
        chk("d_cmd2",  64'(o_page_cmd), 64'hD200);
        chk("d_valid2", 64'(o_page_cmd_valid), 64'd1);
        tick();
        chk("d_drain", 64'(o_page_cmd_valid), 64'd0);

        // reset in GRANT with an output beat pending
        set_req(REQ_RD, 1'b1, 16'hE000, 1'b0, 16'h30, 48'h0, 32'h0);
        tick();
        chk("e_grant", 64'(o_grant), 64'd0);
        tick();
        chk("e_valid", 64'(o_page_cmd_valid), 64'd1);
        chk("e_busy",  64'(o_busy), 64'd1);
        do_reset();
        chk("e_valid_rst", 64'(o_page_cmd_valid), 64'd0);
        chk("e_busy_rst",  64'(o_busy), 64'd0);
        chk("e_grant_rst", 64'(o_grant), 64'd2);
        chk("e_ready_rst", 64'(o_req_ready), 64'd0);
        chk("e_cmd_rst",   64'(o_page_cmd), 64'd0);

        // granted requester stalls mid-sequence while erase waits
        set_req(REQ_RD, 1'b1, 16'hF000, 1'b0, 16'h40, 48'h0, 32'h0);
        set_req(REQ_ERASE, 1'b1, 16'hF200, 1'b1, 16'h42, 48'h0, 32'h0);
        tick();
        chk("f_grant", 64'(o_grant), 64'd0);
        tick();
        i_req_valid[REQ_RD] = 1'b0;
        chk("f_beat0", 64'(o_page_cmd), 64'hF000);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("f_hold_grant", 64'(o_grant), 64'd0);
            chk("f_hold_busy",  64'(o_busy), 64'd1);
            chk("f_hold_ready", 64'(o_req_ready), 64'b001);
        end
        set_req(REQ_RD, 1'b1, 16'hF001, 1'b1, 16'h40, 48'h0, 32'h0);
        tick();
        i_req_valid[REQ_RD] = 1'b0;
        chk("f_beat1", 64'(o_page_cmd), 64'hF001);
        chk("f_last",  64'(o_page_cmd_last), 64'd1);
        tick();
        chk("f_grant2", 64'(o_grant), 64'd2);
        tick();
        i_req_valid[REQ_ERASE] = 1'b0;
        chk("f_erase_cmd", 64'(o_page_cmd), 64'hF200);
        chk("f_erase_id",  64'(o_page_cmd_id), 64'h42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
